serial_addsub_unit: RTL and testbench
=====================================

SERIAL_ADDSUB_UNIT -- requirements
Module: serial_addsub_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be at least 2.
REQ-002 Parameter DIGIT, default 4: bits processed per cycle; SHALL divide WIDTH exactly. N = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin, cin acts as borrow-in).
REQ-007 a  input  WIDTH  minuend or addend, unsigned / two's complement.
REQ-008 b  input  WIDTH  subtrahend or addend.
REQ-009 cin  input  1  carry-in for add, borrow-in for subtract.
REQ-010 busy  output  1  high while an accepted operation is in progress.
REQ-011 done  output  1  one-cycle pulse; results valid.
REQ-012 s  output  WIDTH  sum or difference.
REQ-013 cout  output  1  carry-out for add, borrow-out for subtract.
REQ-014 ovf  output  1  signed two's-complement overflow.
REQ-015 zero  output  1  high when s is all zeros.

Function
REQ-016 FSM states: IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after N digit cycles; DONE->IDLE unconditionally after one cycle.
REQ-017 Accept edge E0: IDLE with start=1; a, b, cin, mode latched; digit counter cleared; busy=1 from E0.
REQ-018 Edges E1..EN: each processes one DIGIT-bit slice, LSB slice first; carry/borrow is propagated between slices in a one-bit register.
REQ-019 Subtract slice: bit difference a^b^borrow; borrow-out (~a&b)|(borrow&~(a^b)); add slice: a^b^carry, carry-out (a&b)|(carry&(a^b)).
REQ-020 At EN: s, cout, ovf and zero are loaded together; busy=0 and done=1 for exactly the cycle EN..EN+1.
REQ-021 s, cout, ovf and zero SHALL change only at EN (no partial results visible); they hold until the next EN.
REQ-022 Add overflow: a[MSB]==b[MSB] and s[MSB]!=a[MSB]; subtract overflow: a[MSB]!=b[MSB] and s[MSB]!=a[MSB].
REQ-023 start in RUN or DONE is ignored, and the operands of the in-flight operation are unaffected; start in the DONE cycle is not queued.
REQ-024 Input changes on a, b, cin and mode after E0 have no effect on the in-flight operation.
REQ-025 Back-to-back throughput: one operation per N+2 cycles maximum.

Reset
REQ-026 rst_n=0 immediately forces IDLE; busy, done, s, cout, ovf, zero = 0; the internal carry and counter = 0.
REQ-027 Reset during RUN or DONE aborts the operation; done SHALL NOT pulse for the aborted operation.
REQ-028 After rst_n rises, the first start accepted in IDLE completes normally.

Verification (WIDTH=16, DIGIT=4, N=4 unless stated)
REQ-029 mode=1, a=0x0005, b=0x0007, cin=0 -> at E4: s=0xFFFE, cout=1, ovf=0, zero=0; done high for one cycle; busy high E0..E4.
REQ-030 mode=0, a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1; mode=0, a=0xFFFF, b=0x0001 -> s=0x0000, cout=1, zero=1, ovf=0.
REQ-031 mode=1, a=b=0x1234, cin=0 -> s=0x0000, zero=1, cout=0; mode=1, a=b=0x0000, cin=1 -> s=0xFFFF, cout=1, ovf=0.
REQ-032 Start with a=0x0010, b=0x0001 (sub); pulse start with a=0x9999 at E2 -> result 0x000F only, exactly one done.
REQ-033 Reset asserted at E2 of a run -> all outputs 0 immediately, no done; next operation 0x0003+0x0004 -> s=0x0007 at its E4.
REQ-034 WIDTH=8, DIGIT=1 (N=8): mode=1, a=0x80, b=0x01 -> done at E8, s=0x7F, ovf=1, cout=0.

Source files
------------

// File: rtl/serial_addsub_unit.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB slice first,
// and publishes sum/difference plus carry, overflow and zero flags all at once.
module serial_addsub_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub_unit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               mode_q;
  logic               a_msb, b_msb;
  logic [WIDTH-1:0]   a_sh, b_sh, res_sh;
  logic [DIGIT:0]     slice;
  logic [WIDTH-1:0]   res_nxt;
  logic               accept;
  logic               last;

  // One DIGIT-wide ripple slice; returns {carry/borrow out, result digit}.
  function automatic logic [DIGIT:0] slice_op(input logic [DIGIT-1:0] x,
                                              input logic [DIGIT-1:0] y,
                                              input logic             c_in,
                                              input logic             sub);
    logic             c;
    logic [DIGIT-1:0] d;
    c = c_in;
    d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ c;
      if (sub) c = (~x[i] & y[i]) | (c & ~(x[i] ^ y[i]));
      else     c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, d};
  endfunction

  function automatic logic overflow(input logic sub, input logic am,
                                    input logic bm, input logic sm);
    if (sub) return (am != bm) && (sm != am);
    else     return (am == bm) && (sm != am);
  endfunction

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CNT_W'(N - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    slice   = slice_op(a_sh[DIGIT-1:0], b_sh[DIGIT-1:0], carry, mode_q);
    res_nxt = res_sh >> DIGIT;
    res_nxt[WIDTH-1 -: DIGIT] = slice[DIGIT-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= '0;
        carry  <= cin;
        mode_q <= mode;
      end else if (state == RUN) begin
        cnt   <= cnt + CNT_W'(1);
        carry <= slice[DIGIT];
      end
    end
  end

  // Operand/partial-result shifters: every bit is rewritten before it is used,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res_sh <= res_nxt;
    end
  end

  // Visible results update only on the final digit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if ((state == RUN) && last) begin
      s    <= res_nxt;
      cout <= slice[DIGIT];
      ovf  <= overflow(mode_q, a_msb, b_msb, res_nxt[WIDTH-1]);
      zero <= (res_nxt == '0);
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit: a 16/4 instance and an 8/1 instance.
module tb_serial_addsub_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, mode, cin;
  logic [15:0] a, b, s;
  logic        busy, done, cout, ovf, zero;

  logic        start8, mode8, cin8;
  logic [7:0]  a8, b8, s8;
  logic        busy8, done8, cout8, ovf8, zero8;

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .cin(cin), .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf),
    .zero(zero));

  serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8),
    .zero(zero8));

  typedef struct packed {logic [15:0] s; logic c; logic o; logic z;} exp_t;
  exp_t q[$];
  exp_t q8[$];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_s = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) chk("unexpected_done16", 1, 0);
      else begin
        e = q.pop_front();
        chk("s", s, e.s);
        chk("cout", cout, e.c);
        chk("ovf", ovf, e.o);
        chk("zero", zero, e.z);
        chk("busy_low_at_done", busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("s8", s8, e.s);
        chk("cout8", cout8, e.c);
        chk("ovf8", ovf8, e.o);
        chk("zero8", zero8, e.z);
      end
    end
  end

  task automatic wait_done16(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      chk("s_hold_while_busy", s, last_s);
      @(negedge clk);
      lat++;
    end
    if (!done) chk("timeout16", 0, 1);
  endtask

  task automatic run_op(input logic m, input logic [15:0] aa, input logic [15:0] bb,
                        input logic c, input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    mode = m; a = aa; b = bb; cin = c; start = 1'b1;
    q.push_back('{es, ec, eo, ez});
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    start = 1'b0; a = ~aa; b = aa ^ 16'h5a5a; mode = ~m; cin = ~c;
    wait_done16(lat);
    chk("latency16", lat, 5);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    last_s = es;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 0; mode = 0; cin = 0; a = '0; b = '0;
    start8 = 0; mode8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_s", s, 0);
    chk("reset_flags", {cout, ovf, zero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1, 0, 0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1);
    run_op(1'b0, 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 0, 0, 0);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 0, 1, 0);
    run_op(1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 0, 0, 1);
    run_op(1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1, 0, 0);

    // start while running and in DONE is ignored
    @(negedge clk);
    mode = 1; a = 16'h0010; b = 16'h0001; cin = 0; start = 1;
    q.push_back('{16'h000F, 1'b0, 1'b0, 1'b0});
    @(negedge clk); start = 0;
    @(negedge clk); start = 1; a = 16'h9999;
    @(negedge clk); start = 0;
    lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    if (!done) chk("timeout_ignore", 0, 1);
    start = 1;
    @(negedge clk); start = 0;
    chk("done_not_repeated", done, 0);
    @(negedge clk);
    chk("start_in_done_not_queued", busy, 0);
    repeat (6) @(negedge clk);
    last_s = 16'h000F;

    // reset in the middle of a run
    @(negedge clk);
    mode = 0; a = 16'h1111; b = 16'h2222; cin = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_s", s, 0);
    chk("abort_flags", {cout, ovf, zero}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_s = 16'h0;
    repeat (6) @(negedge clk);
    chk("no_done_after_abort", busy, 0);
    run_op(1'b0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 0, 0, 0);

    // 8-bit, one bit per cycle
    @(negedge clk);
    mode8 = 1; a8 = 8'h80; b8 = 8'h01; cin8 = 0; start8 = 1;
    q8.push_back('{16'h007F, 1'b0, 1'b1, 1'b0});
    @(negedge clk); start8 = 0; a8 = 8'h00; b8 = 8'hFF; mode8 = 0;
    chk("busy8_after_accept", busy8, 1);
    lat = 1;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    if (!done8) chk("timeout8", 0, 1);
    else chk("latency8", lat, 9);

    repeat (4) @(negedge clk);
    chk("queues_drained", q.size() + q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
